// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with single-cycle arith/logic/shift ops and a bit-serial multiplier.
// Define SEQ_ALU_DIV_EN to add a restoring divider for UDIV/UMOD (otherwise they are illegal).
module seq_alu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_oper,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_illegal
);

  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpAdc = 4'd1;
  localparam logic [3:0] OpSub = 4'd2;
  localparam logic [3:0] OpSbc = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4;
  localparam logic [3:0] OpOr  = 4'd5;
  localparam logic [3:0] OpXor = 4'd6;
  localparam logic [3:0] OpLsl = 4'd7;
  localparam logic [3:0] OpLsr = 4'd8;
  localparam logic [3:0] OpAsr = 4'd9;
  localparam logic [3:0] OpMul = 4'd10;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OpUdiv = 4'd11;
  localparam logic [3:0] OpUmod = 4'd12;
`endif

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [1:0]       vc_q, vc_d;
  logic [3:0]       oflags_q, oflags_d;
  logic             ill_q, ill_d;
  logic [ShW-1:0]   cnt_q, cnt_d;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH:0]   rem_sh;
  logic             div_ge;
`endif

  function automatic logic is_long(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return (op == OpMul) || (op == OpUdiv) || (op == OpUmod);
`else
    return op == OpMul;
`endif
  endfunction

  // Single-cycle datapath, evaluated on the live inputs and captured at accept.
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             alu_ill;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             cin;
  logic             sh_big;
  logic [ShW-1:0]   sh_amt;

  always_comb begin
    alu_res   = '0;
    alu_flags = in_flags;
    alu_ill   = 1'b0;
    b_op      = ((in_oper == OpSub) || (in_oper == OpSbc)) ? ~in_b : in_b;
    case (in_oper)
      OpAdc, OpSbc: cin = in_flags[0];
      OpSub:        cin = 1'b1;
      default:      cin = 1'b0;
    endcase
    sum    = {1'b0, in_a} + {1'b0, b_op} + {{WIDTH{1'b0}}, cin};
    sh_big = (in_b >> ShW) != '0;
    sh_amt = in_b[ShW-1:0];
    case (in_oper)
      OpAdd, OpAdc, OpSub, OpSbc: begin
        alu_res      = sum[WIDTH-1:0];
        alu_flags[0] = sum[WIDTH];
        // b_op is the effective addend, so one overflow rule covers add and subtract.
        alu_flags[2] = ~(in_a[WIDTH-1] ^ b_op[WIDTH-1]) & (in_a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OpAnd:   alu_res = in_a & in_b;
      OpOr:    alu_res = in_a | in_b;
      OpXor:   alu_res = in_a ^ in_b;
      OpLsl:   alu_res = sh_big ? '0 : in_a << sh_amt;
      OpLsr:   alu_res = sh_big ? '0 : in_a >> sh_amt;
      OpAsr:   alu_res = sh_big ? {WIDTH{in_a[WIDTH-1]}} : $unsigned($signed(in_a) >>> sh_amt);
      default: alu_ill = 1'b1;
    endcase
    if (!alu_ill && !((in_oper == OpLsl) || (in_oper == OpLsr) || (in_oper == OpAsr))) begin
      alu_flags[3] = alu_res[WIDTH-1];
      alu_flags[1] = (alu_res == '0);
    end
  end

  // Iterative datapath: {acc, sh} is the product/quotient shift pair.
  logic [WIDTH:0] mul_sum;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    acc_d    = acc_q;
    sh_d     = sh_q;
    res_d    = res_q;
    vc_d     = vc_q;
    oflags_d = oflags_q;
    ill_d    = ill_q;
    cnt_d    = cnt_q;
    mul_sum  = {1'b0, acc_q} + {1'b0, (sh_q[0] ? a_q : {WIDTH{1'b0}})};
`ifdef SEQ_ALU_DIV_EN
    b_d    = b_q;
    rem_sh = {acc_q, sh_q[WIDTH-1]};
    div_ge = rem_sh >= {1'b0, b_q};
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d  = in_oper;
          a_d   = in_a;
          vc_d  = {in_flags[2], in_flags[0]};
          acc_d = '0;
          cnt_d = '0;
          if (is_long(in_oper)) begin
            state_d = StBusy;
            sh_d    = (in_oper == OpMul) ? in_b : in_a;
`ifdef SEQ_ALU_DIV_EN
            b_d     = in_b;
`endif
          end else begin
            state_d  = StDone;
            res_d    = alu_res;
            oflags_d = alu_flags;
            ill_d    = alu_ill;
          end
        end
      end
      StBusy: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OpMul) begin
          acc_d = mul_sum[WIDTH:1];
          sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
        end
`ifdef SEQ_ALU_DIV_EN
        else begin
          acc_d = div_ge ? (rem_sh[WIDTH-1:0] - b_q) : rem_sh[WIDTH-1:0];
          sh_d  = {sh_q[WIDTH-2:0], div_ge};
        end
`endif
        if (cnt_q == ShW'(WIDTH - 1)) begin
          state_d  = StDone;
          ill_d    = 1'b0;
          res_d    = sh_d;
          oflags_d = {sh_d[WIDTH-1], vc_q[1], (sh_d == '0), vc_q[0]};
`ifdef SEQ_ALU_DIV_EN
          if (op_q == OpUmod) res_d = acc_d;
          if (op_q != OpMul) oflags_d = {res_d[WIDTH-1], (b_q == '0), (res_d == '0), 1'b0};
`endif
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      acc_q    <= '0;
      sh_q     <= '0;
      res_q    <= '0;
      vc_q     <= '0;
      oflags_q <= '0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
`ifdef SEQ_ALU_DIV_EN
      b_q      <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      acc_q    <= acc_d;
      sh_q     <= sh_d;
      res_q    <= res_d;
      vc_q     <= vc_d;
      oflags_q <= oflags_d;
      ill_q    <= ill_d;
      cnt_q    <= cnt_d;
`ifdef SEQ_ALU_DIV_EN
      b_q      <= b_d;
`endif
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign out_result  = res_q;
  assign out_flags   = oflags_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: a 32-bit and an 8-bit instance, directed vectors,
// expected responses queued at accept and checked by a negedge monitor.
module tb_seq_alu;

  localparam logic [3:0] OpAdd = 4'd0, OpAdc = 4'd1, OpSub = 4'd2, OpSbc = 4'd3;
  localparam logic [3:0] OpAnd = 4'd4, OpOr = 4'd5, OpXor = 4'd6, OpLsl = 4'd7;
  localparam logic [3:0] OpLsr = 4'd8, OpAsr = 4'd9, OpMul = 4'd10, OpUdiv = 4'd11;
  localparam logic [3:0] OpUmod = 4'd12;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    logic        ill;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  logic        rst[2];
  logic        vld[2];
  logic [3:0]  op[2];
  logic [31:0] ia[2];
  logic [31:0] ib[2];
  logic [3:0]  ifl[2];
  logic        rdy[2];

  logic        irdy0, ov0, ill0;
  logic [31:0] res0;
  logic [3:0]  fl0;
  logic        irdy1, ov1, ill1;
  logic [7:0]  res1;
  logic [3:0]  fl1;

  exp_t q0[$];
  exp_t q1[$];

  seq_alu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst[0]), .in_valid(vld[0]), .in_ready(irdy0), .in_oper(op[0]),
    .in_a(ia[0]), .in_b(ib[0]), .in_flags(ifl[0]), .out_valid(ov0), .out_ready(rdy[0]),
    .out_result(res0), .out_flags(fl0), .out_illegal(ill0)
  );

  seq_alu #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst[1]), .in_valid(vld[1]), .in_ready(irdy1), .in_oper(op[1]),
    .in_a(ia[1][7:0]), .in_b(ib[1][7:0]), .in_flags(ifl[1]), .out_valid(ov1),
    .out_ready(rdy[1]), .out_result(res1), .out_flags(fl1), .out_illegal(ill1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic get_irdy(input int d);
    return (d == 0) ? irdy0 : irdy1;
  endfunction

  // Waits (bounded) until the DUT is idle; inputs change only at posedge+1.
  task automatic wait_ready(input int d, output logic ok);
    int n = 0;
    ok = 1'b1;
    while (get_irdy(d) !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL wait_ready d%0d: in_ready still %b after 200 cycles, required 1", d,
                 get_irdy(d));
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic issue(input int d, input logic [3:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] f, input logic [31:0] er,
                       input logic [3:0] ef, input logic eill, input int elat,
                       input string nm);
    exp_t e;
    logic ok;
    wait_ready(d, ok);
    if (!ok) return;
    op[d]  = o;
    ia[d]  = a;
    ib[d]  = b;
    ifl[d] = f;
    vld[d] = 1'b1;
    @(posedge clk);
    #1;
    e.res  = er;
    e.fl   = ef;
    e.ill  = eill;
    e.lat  = elat;
    e.acc  = cyc - 1;
    e.name = nm;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    vld[d] = 1'b0;
    op[d]  = 4'($urandom);
    ia[d]  = $urandom;
    ib[d]  = $urandom;
    ifl[d] = 4'($urandom);
  endtask

  // Monitor: latency and hold-stability while stalled, compare on transfer.
  logic        pv[2];
  logic [31:0] sres[2];
  logic [3:0]  sfl[2];
  logic        sill[2];

  initial begin
    pv[0] = 1'b0;
    pv[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        logic        v, ir, il;
        logic [31:0] rs;
        logic [3:0]  f;
        int          n;
        exp_t        e;
        v  = (d == 0) ? ov0 : ov1;
        ir = (d == 0) ? irdy0 : irdy1;
        il = (d == 0) ? ill0 : ill1;
        rs = (d == 0) ? res0 : {24'h0, res1};
        f  = (d == 0) ? fl0 : fl1;
        n  = (d == 0) ? q0.size() : q1.size();
        if (v === 1'b1) begin
          chk($sformatf("in_ready_while_valid d%0d", d), {31'h0, ir}, 32'h0);
          if (n == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output d%0d: got out_valid=1 result %h, required none", d,
                     rs);
          end else begin
            e = (d == 0) ? q0[0] : q1[0];
            if (!pv[d]) begin
              chk($sformatf("%s latency d%0d", e.name, d), cyc - e.acc, e.lat);
              sres[d] = rs;
              sfl[d]  = f;
              sill[d] = il;
            end else begin
              chk($sformatf("%s hold_result d%0d", e.name, d), rs, sres[d]);
              chk($sformatf("%s hold_flags d%0d", e.name, d), {28'h0, f}, {28'h0, sfl[d]});
              chk($sformatf("%s hold_illegal d%0d", e.name, d), {31'h0, il}, {31'h0, sill[d]});
            end
            if (rdy[d]) begin
              if (d == 0) void'(q0.pop_front());
              else void'(q1.pop_front());
              chk($sformatf("%s result d%0d", e.name, d), rs, e.res);
              chk($sformatf("%s flags d%0d", e.name, d), {28'h0, f}, {28'h0, e.fl});
              chk($sformatf("%s illegal d%0d", e.name, d), {31'h0, il}, {31'h0, e.ill});
            end
          end
        end
        pv[d] = (v === 1'b1) && !rdy[d];
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      vld[d] = 1'b0;
      op[d]  = 4'h0;
      ia[d]  = '0;
      ib[d]  = '0;
      ifl[d] = 4'h0;
      rdy[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    chk("reset in_ready d0", {31'h0, irdy0}, 32'h1);
    chk("reset out_valid d0", {31'h0, ov0}, 32'h0);
    chk("reset out_result d0", res0, 32'h0);
    chk("reset out_flags d0", {28'h0, fl0}, 32'h0);
    chk("reset out_illegal d0", {31'h0, ill0}, 32'h0);
    chk("reset in_ready d1", {31'h0, irdy1}, 32'h1);
    chk("reset out_valid d1", {31'h0, ov1}, 32'h0);

    // 32-bit instance: flags are {N,V,Z,C}.
    issue(0, OpAdd, 32'h7FFF_FFFF, 32'h1, 4'b0000, 32'h8000_0000, 4'b1100, 1'b0, 1, "add_ovf");
    issue(0, OpSub, 32'd5, 32'd5, 4'b0000, 32'h0, 4'b0011, 1'b0, 1, "sub_eq");
    issue(0, OpAdc, 32'hFFFF_FFFF, 32'h0, 4'b0001, 32'h0, 4'b0011, 1'b0, 1, "adc_wrap");
    issue(0, OpSbc, 32'h0, 32'h0, 4'b0000, 32'hFFFF_FFFF, 4'b1000, 1'b0, 1, "sbc_borrow");
    issue(0, OpSub, 32'h8000_0000, 32'h1, 4'b0000, 32'h7FFF_FFFF, 4'b0101, 1'b0, 1, "sub_ovf");
    issue(0, OpAnd, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0101, 32'hF000_F000, 4'b1101, 1'b0, 1,
          "and");
    issue(0, OpOr, 32'h0, 32'h0, 4'b1001, 32'h0, 4'b0011, 1'b0, 1, "or_zero");
    issue(0, OpLsl, 32'h1, 32'd31, 4'b1010, 32'h8000_0000, 4'b1010, 1'b0, 1, "lsl31");
    issue(0, OpLsl, 32'h1, 32'd32, 4'b0101, 32'h0, 4'b0101, 1'b0, 1, "lsl32");
    issue(0, OpLsr, 32'h8000_0000, 32'd4, 4'b0000, 32'h0800_0000, 4'b0000, 1'b0, 1, "lsr4");
    issue(0, OpAsr, 32'h8000_0000, 32'd4, 4'b0000, 32'hF800_0000, 4'b0000, 1'b0, 1, "asr4");
    issue(0, OpAsr, 32'h8000_0000, 32'h100, 4'b0000, 32'hFFFF_FFFF, 4'b0000, 1'b0, 1,
          "asr_big");
    issue(0, OpAsr, 32'h4000_0000, 32'd40, 4'b0000, 32'h0, 4'b0000, 1'b0, 1, "asr_big_pos");
    issue(0, 4'd13, 32'h1, 32'h2, 4'b1011, 32'h0, 4'b1011, 1'b1, 1, "unused13");
    issue(0, OpMul, 32'h1_0000, 32'h1_0001, 4'b0110, 32'h0001_0000, 4'b0100, 1'b0, 33, "mul32");
`ifdef SEQ_ALU_DIV_EN
    issue(0, OpUdiv, 32'd100, 32'd0, 4'b0000, 32'hFFFF_FFFF, 4'b1100, 1'b0, 33, "udiv_by0");
    issue(0, OpUmod, 32'd100, 32'd7, 4'b1111, 32'd2, 4'b0000, 1'b0, 33, "umod7");
    issue(0, OpUdiv, 32'd100, 32'd7, 4'b1111, 32'd14, 4'b0000, 1'b0, 33, "udiv7");
    issue(0, OpUmod, 32'd100, 32'd0, 4'b0000, 32'd100, 4'b0100, 1'b0, 33, "umod_by0");
`else
    issue(0, OpUdiv, 32'd100, 32'd0, 4'b0001, 32'h0, 4'b0001, 1'b1, 1, "udiv_absent");
    issue(0, OpUmod, 32'd100, 32'd7, 4'b1111, 32'h0, 4'b1111, 1'b1, 1, "umod_absent");
`endif

    // Back-pressure: result must hold while inputs churn and in_valid is ignored.
    wait_ready(0, ok);
    rdy[0] = 1'b0;
    issue(0, OpXor, 32'hA5A5_A5A5, 32'hFFFF_0000, 4'b0000, 32'h5A5A_A5A5, 4'b0000, 1'b0, 1,
          "xor_bp");
    repeat (5) begin
      ia[0]  = ~ia[0];
      vld[0] = 1'b1;
      op[0]  = OpAdd;
      @(posedge clk);
      #1;
    end
    vld[0] = 1'b0;
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp in_ready_after", {31'h0, irdy0}, 32'h1);
    chk("bp out_valid_after", {31'h0, ov0}, 32'h0);

    // 8-bit instance.
    issue(1, OpMul, 32'h13, 32'h11, 4'b0101, 32'h43, 4'b0101, 1'b0, 9, "mul8");
    issue(1, OpMul, 32'hFF, 32'hFF, 4'b0000, 32'h01, 4'b0000, 1'b0, 9, "mul8_ff");
    issue(1, OpMul, 32'h10, 32'h10, 4'b0000, 32'h00, 4'b0010, 1'b0, 9, "mul8_zero");
    issue(1, OpAdd, 32'h7F, 32'h1, 4'b0000, 32'h80, 4'b1100, 1'b0, 1, "add8_ovf");
    issue(1, OpLsl, 32'h1, 32'd8, 4'b1000, 32'h0, 4'b1000, 1'b0, 1, "lsl8_big");
    issue(1, OpLsl, 32'h81, 32'd7, 4'b0000, 32'h80, 4'b0000, 1'b0, 1, "lsl8_7");
    issue(1, OpAsr, 32'h80, 32'd9, 4'b0000, 32'hFF, 4'b0000, 1'b0, 1, "asr8_big");

    // Reset during the third BUSY cycle of a multiply, with a competing request.
    wait_ready(1, ok);
    op[1]  = OpMul;
    ia[1]  = 32'h13;
    ib[1]  = 32'h11;
    ifl[1] = 4'b0000;
    vld[1] = 1'b1;
    @(posedge clk);
    #1;
    vld[1] = 1'b0;
    chk("rst_mid busy in_ready", {31'h0, irdy1}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst[1] = 1'b1;
    vld[1] = 1'b1;
    op[1]  = OpAdd;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    vld[1] = 1'b0;
    chk("rst_mid in_ready", {31'h0, irdy1}, 32'h1);
    chk("rst_mid out_valid", {31'h0, ov1}, 32'h0);
    chk("rst_mid out_result", {24'h0, res1}, 32'h0);
    chk("rst_mid out_flags", {28'h0, fl1}, 32'h0);
    chk("rst_mid out_illegal", {31'h0, ill1}, 32'h0);
    issue(1, OpMul, 32'h3, 32'h5, 4'b0000, 32'h0F, 4'b0000, 1'b0, 9, "mul8_after_rst");

    for (int i = 0; i < 200 && (q0.size() != 0 || q1.size() != 0); i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain q32", q0.size(), 32'h0);
    chk("drain q8", q1.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
